sys_bus_arbiter: RTL

Parametrised arbiter between N pipeline masters and the single shared sys_bus port. It replaces the hard-wired "MEM stage steals the bus from IF" mux. Each master gets a request/grant/response handshake, with fixed-priority or round-robin arbitration and a configurable slave latency. It sits between the pipeline stages (fetch, data, future DMA/debug ports) and the bus.

---
 rtl/sys_bus_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sys_bus_arbiter.sv
// Arbiter between NUM_M pipeline masters and the single shared sys_bus port.
// One transaction at a time: IDLE picks a winner, ACCESS holds the owner's
// request on the bus for LAT cycles, RESP pulses the owner's m_rvalid.
module sys_bus_arbiter #(
  parameter int unsigned NUM_M  = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MODE   = 0,
  parameter int unsigned LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_req,
  input  logic [3*NUM_M-1:0]        m_rd_ctrl,
  input  logic [3*NUM_M-1:0]        m_wr_ctrl,
  input  logic [ADDR_W*NUM_M-1:0]   m_addr,
  input  logic [DATA_W*NUM_M-1:0]   m_din,
  output logic [NUM_M-1:0]          m_gnt,
  output logic [NUM_M-1:0]          m_rvalid,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [2:0]                bus_rd_ctrl,
  output logic [2:0]                bus_wr_ctrl,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_din,
  input  logic [DATA_W-1:0]         bus_dout
);

  localparam int unsigned IdxW = $clog2(NUM_M);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   winner;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              any_req;

  assign any_req = |m_req;
  assign m_rdata = rdata_q;

  // Winner selection: lowest index (fixed) or first index after rr_ptr (round robin).
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    if (MODE == 0) begin
      // Scan downward so the lowest requesting index is assigned last.
      for (int i = int'(NUM_M) - 1; i >= 0; i--) begin
        if (m_req[i]) winner = IdxW'(i);
      end
    end else begin
      // Scan offsets downward so the smallest offset from rr_ptr+1 wins.
      for (int unsigned i = NUM_M; i >= 1; i--) begin
        idx = (32'(rr_ptr_q) + i) % NUM_M;
        if (m_req[idx]) winner = IdxW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: if (cnt_q == 4'd0) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Owner, latency counter, round-robin pointer and response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= '0;
      rr_ptr_q <= IdxW'(NUM_M - 1);
      cnt_q    <= 4'd0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q  <= winner;
            rr_ptr_q <= winner;
            cnt_q    <= 4'(LAT - 1);
          end
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            rdata_q <= bus_dout;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: bus mirrors the owner only in ACCESS; everything else idles at zero.
  always_comb begin
    m_gnt       = '0;
    m_rvalid    = '0;
    bus_rd_ctrl = 3'd0;
    bus_wr_ctrl = 3'd0;
    bus_addr    = '0;
    bus_din     = '0;
    case (state_q)
      StAccess: begin
        m_gnt[owner_q] = 1'b1;
        for (int unsigned i = 0; i < NUM_M; i++) begin
          if (owner_q == IdxW'(i)) begin
            bus_rd_ctrl = m_rd_ctrl[3*i +: 3];
            bus_wr_ctrl = m_wr_ctrl[3*i +: 3];
            bus_addr    = m_addr[ADDR_W*i +: ADDR_W];
            bus_din     = m_din[DATA_W*i +: DATA_W];
          end
        end
      end
      StResp:  m_rvalid[owner_q] = 1'b1;
      default: ;
    endcase
  end

endmodule
